// File: rtl/digct_seq_ctrl.sv
// rtl/digct_seq_ctrl.sv - vector sequencer and self-checker for the DigCt datapath
//
// Holds a loadable table of DEPTH five-bit stimulus vectors, each with a
// three-bit expected response. A run applies each vector to DigCt for HOLD
// cycles and samples DigCt's outputs on the last edge of that window, so
// DigCt may have up to HOLD-1 cycles of output latency.
//
// Optional feature macro: DIGCT_SEQ_CMP_EN
//   defined   : expected-value table, comparator, err_cnt_o, fail_idx_o and
//               pass_o are built.
//   undefined : pure sequencer. wr_exp_i and dut_out_i are ignored,
//               err_cnt_o / fail_idx_o stay 0, pass_o is 1 at done_o.
//
// Ports:
//   clk_i       clock, rising edge
//   rst_i       synchronous active-high reset
//   wr_en_i     table write strobe (honoured in IDLE only)
//   wr_addr_i   table entry index
//   wr_vec_i    stimulus vector, bit 4 = IN1 ... bit 0 = IN5
//   wr_exp_i    expected response, bit 2 = OUT1 ... bit 0 = OUT3
//   start_i     begin a run (honoured in IDLE only)
//   abort_i     stop a run; wins over start_i in IDLE
//   dut_in_o    {IN1..IN5} to DigCt, registered
//   dut_out_i   {OUT1..OUT3} from DigCt
//   busy_o      high while vectors are being applied
//   done_o      one-cycle pulse at run completion
//   pass_o      no mismatches in the completed run
//   err_cnt_o   number of mismatching vectors in the last run
//   fail_idx_o  index of the first mismatching vector

module digct_seq_ctrl #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int HOLD  = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [4:0]    wr_vec_i,
  input  logic [2:0]    wr_exp_i,
  input  logic          start_i,
  input  logic          abort_i,
  output logic [4:0]    dut_in_o,
  input  logic [2:0]    dut_out_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          pass_o,
  output logic [AW:0]   err_cnt_o,
  output logic [AW-1:0] fail_idx_o
);

  // Hold counter needs at least one bit even when HOLD == 1.
  localparam int            HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [AW-1:0] IDX_LAST  = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_FIN   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [4:0]    dut_in_q, dut_in_d;
  logic [AW:0]   err_cnt_q, err_cnt_d;
  logic [AW-1:0] fail_idx_q, fail_idx_d;
  logic          pass_q, pass_d;

  logic          run_accept;  // START accepted this cycle
  logic          last_cmp;    // final edge of the current hold window
  logic          mismatch;    // sampled DigCt output differs from expectation

  // Stimulus table: not reset, written only while idle.
  logic [4:0] vec_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i && (state_q == ST_IDLE)) begin
      vec_mem[wr_addr_i] <= wr_vec_i;
    end
  end

`ifdef DIGCT_SEQ_CMP_EN
  logic [2:0] exp_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i && (state_q == ST_IDLE)) begin
      exp_mem[wr_addr_i] <= wr_exp_i;
    end
  end

  assign mismatch = (dut_out_i != exp_mem[idx_q]);
`else
  // No expectation storage: nothing can mismatch, so err_cnt/fail_idx
  // never leave their cleared value and pass is 1 at completion.
  logic unused_cmp_inputs;
  assign unused_cmp_inputs = ^{wr_exp_i, dut_out_i};
  assign mismatch          = 1'b0;
`endif

  assign run_accept = start_i && !abort_i;
  assign last_cmp   = (hold_q == HOLD_LAST);

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (run_accept) begin
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (last_cmp && (idx_q == IDX_LAST)) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM: outputs decoded from the state register
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_q)
      ST_APPLY: busy_o = 1'b1;
      ST_FIN:   done_o = 1'b1;
      default: begin
        busy_o = 1'b0;
        done_o = 1'b0;
      end
    endcase
  end

  // Datapath next-state: vector index, hold counter, registered stimulus
  // and result registers.
  always_comb begin
    idx_d      = idx_q;
    hold_d     = hold_q;
    dut_in_d   = dut_in_q;
    err_cnt_d  = err_cnt_q;
    fail_idx_d = fail_idx_q;
    pass_d     = pass_q;
    case (state_q)
      ST_IDLE: begin
        dut_in_d = 5'd0;
        if (run_accept) begin
          idx_d      = '0;
          hold_d     = '0;
          err_cnt_d  = '0;
          fail_idx_d = '0;
          pass_d     = 1'b0;
          dut_in_d   = vec_mem[0];
        end
      end
      ST_APPLY: begin
        if (abort_i) begin
          // Partial err_cnt/fail_idx are kept; pass stays 0.
          dut_in_d = 5'd0;
        end else if (last_cmp) begin
          hold_d    = '0;
          idx_d     = idx_q + 1'b1;
          err_cnt_d = err_cnt_q + {{AW{1'b0}}, mismatch};
          if (mismatch && (err_cnt_q == '0)) begin
            fail_idx_d = idx_q;
          end
          if (idx_q == IDX_LAST) begin
            // Result is registered together with the move to FIN so it is
            // valid in the same cycle as done_o.
            dut_in_d = 5'd0;
            pass_d   = (err_cnt_d == '0);
          end else begin
            dut_in_d = vec_mem[idx_d];
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_FIN: begin
        dut_in_d = 5'd0;
      end
      default: begin
        dut_in_d = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q      <= '0;
      hold_q     <= '0;
      dut_in_q   <= '0;
      err_cnt_q  <= '0;
      fail_idx_q <= '0;
      pass_q     <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      hold_q     <= hold_d;
      dut_in_q   <= dut_in_d;
      err_cnt_q  <= err_cnt_d;
      fail_idx_q <= fail_idx_d;
      pass_q     <= pass_d;
    end
  end

  assign dut_in_o   = dut_in_q;
  assign err_cnt_o  = err_cnt_q;
  assign fail_idx_o = fail_idx_q;
  assign pass_o     = pass_q;

endmodule
